// File: rtl/cfi_pkg.sv
// Shared CFI log types and the scheduler state encoding.
package cfi_pkg;

  typedef struct packed {
    logic is_call;
    logic is_ret;
    logic is_jump;
    logic is_branch;
  } cfi_flags_t;

  typedef struct packed {
    logic [31:0] addr_pc;
    logic [31:0] target;
    cfi_flags_t  flags;
  } cfi_log_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, FAULT} cfi_sched_state_e;

  localparam int unsigned LOG_W = $bits(cfi_log_t);

endpackage

// File: rtl/cfi_log_fifo.sv
// Multi-push (one slot per commit port, in port order), single-pop log FIFO
// with a sticky overflow flag for pushes that find no free slot.
module cfi_log_fifo
  import cfi_pkg::*;
#(
  parameter int unsigned NR_PORTS = 2,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  cfi_log_t [NR_PORTS-1:0]   push_log_i,
  input  logic [NR_PORTS-1:0]       push_i,
  input  logic                      pop_i,
  input  logic                      clear_ovf_i,
  output cfi_log_t                  head_o,
  output logic [$clog2(DEPTH):0]    count_next_o,
  output logic                      overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cfi_log_t         mem_q [DEPTH];
  cfi_log_t         mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  // Pop first so its slot is available to this cycle's pushes.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q & ~clear_ovf_i;
    if (pop_i && (count_q != '0)) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_q - CNT_W'(1);
    end
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      if (push_i[i]) begin
        if (count_d < CNT_W'(DEPTH)) begin
          mem_d[wr_ptr_d] = push_log_i[i];
          wr_ptr_d        = wr_ptr_d + PTR_W'(1);
          count_d         = count_d + CNT_W'(1);
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign head_o       = mem_q[rd_ptr_q];
  assign count_next_o = count_d;
  assign overflow_o   = overflow_q;

endmodule

// File: rtl/cfi_log_scheduler.sv
// Serializes buffered CFI logs to the checker, one outstanding check at a time,
// latching the first reported violation and back-pressuring commit.
module cfi_log_scheduler
  import cfi_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  cfi_log_t [NR_COMMIT_PORTS-1:0]   log_i,
  input  logic [NR_COMMIT_PORTS-1:0]       cfi_i,
  input  logic [NR_COMMIT_PORTS-1:0]       commit_ack_i,
  output logic                             stall_o,
  output logic                             req_valid_o,
  input  logic                             req_ready_i,
  output cfi_log_t                         req_log_o,
  input  logic                             resp_valid_i,
  input  logic                             resp_fault_i,
  output logic                             fault_o,
  output cfi_log_t                         fault_log_o,
  output logic                             overflow_o,
  input  logic                             clear_i,
  output logic                             busy_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  cfi_sched_state_e   state_q, state_d;
  cfi_log_t           inflight_q, inflight_d;
  cfi_log_t           fault_log_q, fault_log_d;
  logic               fault_q, fault_d;
  logic               req_valid_q, req_valid_d;
  logic               busy_q, busy_d;
  logic               stall_q, stall_d;
  logic               pop;
  cfi_log_t           head;
  logic [CNT_W-1:0]   count_next;

  assign pop = (state_q == ISSUE) && req_ready_i;

  cfi_log_fifo #(
    .NR_PORTS (NR_COMMIT_PORTS),
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_log_i   (log_i),
    .push_i       (commit_ack_i & cfi_i),
    .pop_i        (pop),
    .clear_ovf_i  (clear_i),
    .head_o       (head),
    .count_next_o (count_next),
    .overflow_o   (overflow_o)
  );

  // Next-state uses next-cycle occupancy so a push is offered one cycle later.
  always_comb begin
    state_d     = state_q;
    inflight_d  = inflight_q;
    fault_d     = fault_q;
    fault_log_d = fault_log_q;
    case (state_q)
      IDLE: if (count_next != '0) state_d = ISSUE;
      ISSUE: begin
        if (req_ready_i) begin
          inflight_d = head;
          state_d    = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (resp_valid_i) begin
          if (resp_fault_i) begin
            state_d     = FAULT;
            fault_d     = 1'b1;
            fault_log_d = inflight_q;
          end else begin
            state_d = (count_next != '0) ? ISSUE : IDLE;
          end
        end
      end
      FAULT: begin
        if (clear_i) begin
          state_d = IDLE;
          fault_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    req_valid_d = (state_d == ISSUE);
    busy_d      = (count_next != '0) || (state_d == WAIT_RESP);
    stall_d     = (CNT_W'(DEPTH) - count_next) < CNT_W'(NR_COMMIT_PORTS);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      inflight_q  <= '0;
      fault_q     <= 1'b0;
      fault_log_q <= '0;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= inflight_d;
      fault_q     <= fault_d;
      fault_log_q <= fault_log_d;
      req_valid_q <= req_valid_d;
      busy_q      <= busy_d;
      stall_q     <= stall_d;
    end
  end

  assign req_valid_o = req_valid_q;
  assign req_log_o   = head;
  assign fault_o     = fault_q;
  assign fault_log_o = fault_log_q;
  assign busy_o      = busy_q;
  assign stall_o     = stall_q;

endmodule

// File: tb/tb_cfi_log_scheduler.sv
// Randomized and directed bench for cfi_log_scheduler against a queue-based model.
module tb_cfi_log_scheduler;
  import cfi_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 8;

  logic           clk_i;
  logic           rst_i;
  cfi_log_t [N-1:0] log_i;
  logic [N-1:0]   cfi_i;
  logic [N-1:0]   commit_ack_i;
  logic           stall_o;
  logic           req_valid_o;
  logic           req_ready_i;
  cfi_log_t       req_log_o;
  logic           resp_valid_i;
  logic           resp_fault_i;
  logic           fault_o;
  cfi_log_t       fault_log_o;
  logic           overflow_o;
  logic           clear_i;
  logic           busy_o;

  cfi_log_scheduler #(.NR_COMMIT_PORTS(N), .DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .log_i        (log_i),
    .cfi_i        (cfi_i),
    .commit_ack_i (commit_ack_i),
    .stall_o      (stall_o),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .req_log_o    (req_log_o),
    .resp_valid_i (resp_valid_i),
    .resp_fault_i (resp_fault_i),
    .fault_o      (fault_o),
    .fault_log_o  (fault_log_o),
    .overflow_o   (overflow_o),
    .clear_i      (clear_i),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Model: pending logs, whether the head is being offered, an outstanding check,
  // the latched fault and the sticky overflow.
  cfi_log_t mq[$];
  bit       m_offer, m_out, m_flt, m_ovf;
  cfi_log_t m_inflight, m_flog;
  cfi_log_t zl;

  task automatic chk(input string name, input logic [LOG_W-1:0] act, input logic [LOG_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cfi_log_t mk(input logic [31:0] pc);
    cfi_log_t l;
    l.addr_pc = pc;
    l.target  = pc + 32'h40;
    l.flags   = pc[5:2];
    return l;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_offer    = 1'b0;
    m_out      = 1'b0;
    m_flt      = 1'b0;
    m_ovf      = 1'b0;
    m_inflight = '0;
    m_flog     = '0;
  endtask

  task automatic compare_all();
    bit exp_stall;
    exp_stall = (DEPTH - mq.size()) < N;
    chk("req_valid", LOG_W'(req_valid_o), LOG_W'(m_offer));
    chk("stall", LOG_W'(stall_o), LOG_W'(exp_stall));
    chk("busy", LOG_W'(busy_o), LOG_W'(mq.size() != 0 || m_out));
    chk("fault", LOG_W'(fault_o), LOG_W'(m_flt));
    chk("fault_log", fault_log_o, m_flog);
    chk("overflow", LOG_W'(overflow_o), LOG_W'(m_ovf));
    if (m_offer) chk("req_log", req_log_o, mq[0]);
  endtask

  // Drive one cycle of inputs, advance the model, then compare at the next negedge.
  task automatic step(input logic [N-1:0] c, input logic [N-1:0] a, input logic rdy,
                      input logic rv, input logic rf, input logic clr,
                      input cfi_log_t l0, input cfi_log_t l1);
    bit popped, ovf_now;
    cfi_i        = c;
    commit_ack_i = a;
    req_ready_i  = rdy;
    resp_valid_i = rv;
    resp_fault_i = rf;
    clear_i      = clr;
    log_i[0]     = l0;
    log_i[1]     = l1;
    popped = m_offer && rdy;
    if (popped) m_inflight = mq.pop_front();
    ovf_now = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (c[i] && a[i]) begin
        if (mq.size() < DEPTH) mq.push_back(log_i[i]);
        else ovf_now = 1'b1;
      end
    end
    if (m_offer) begin
      if (popped) begin
        m_offer = 1'b0;
        m_out   = 1'b1;
      end
    end else if (m_out) begin
      if (rv) begin
        m_out = 1'b0;
        if (rf) begin
          m_flt  = 1'b1;
          m_flog = m_inflight;
        end else begin
          m_offer = mq.size() > 0;
        end
      end
    end else if (m_flt) begin
      if (clr) m_flt = 1'b0;
    end else begin
      m_offer = mq.size() > 0;
    end
    m_ovf = ovf_now || (m_ovf && !clr);
    @(negedge clk_i);
    compare_all();
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (mq.size() > 0 || m_out || m_offer); k++)
      step('0, '0, 1'b1, m_out, 1'b0, 1'b0, zl, zl);
    chk("drain_idle", LOG_W'(busy_o), LOG_W'(1'b0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    zl = '0;
    rst_i = 1'b1;
    cfi_i = '0; commit_ack_i = '0; req_ready_i = 1'b0;
    resp_valid_i = 1'b0; resp_fault_i = 1'b0; clear_i = 1'b0;
    log_i = '0;
    model_reset();
    repeat (2) @(negedge clk_i);
    compare_all();
    chk("rst_req_valid", LOG_W'(req_valid_o), LOG_W'(1'b0));
    chk("rst_busy", LOG_W'(busy_o), LOG_W'(1'b0));
    chk("rst_req_log", req_log_o, '0);
    rst_i = 1'b0;

    // Two pushes, offered next cycle in port order.
    step(2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, mk(32'h8000_0000), mk(32'h8000_0004));
    chk("d1_valid", LOG_W'(req_valid_o), LOG_W'(1'b1));
    chk("d1_pc0", LOG_W'(req_log_o.addr_pc), LOG_W'(32'h8000_0000));
    step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0, zl, zl);
    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, zl, zl);
    step('0, '0, 1'b0, 1'b1, 1'b0, 1'b0, zl, zl);
    chk("d1_pc1", LOG_W'(req_log_o.addr_pc), LOG_W'(32'h8000_0004));
    step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0, zl, zl);
    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, zl, zl);
    step('0, '0, 1'b0, 1'b1, 1'b0, 1'b0, zl, zl);
    chk("d1_busy_drop", LOG_W'(busy_o), LOG_W'(1'b0));

    // CFI without commit ack queues nothing.
    step(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, mk(32'h1), mk(32'h2));
    step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0, zl, zl);
    chk("noack_valid", LOG_W'(req_valid_o), LOG_W'(1'b0));
    chk("noack_busy", LOG_W'(busy_o), LOG_W'(1'b0));

    // Fill with the checker not ready.
    for (int i = 0; i < 3; i++)
      step(2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, mk(32'h9000_0000 + 32'(i*8)), mk(32'h9000_0004 + 32'(i*8)));
    chk("fill6_stall", LOG_W'(stall_o), LOG_W'(1'b0));
    step(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, mk(32'h9000_0100), zl);
    chk("fill7_stall", LOG_W'(stall_o), LOG_W'(1'b1));
    step(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, mk(32'h9000_0104), zl);
    step(2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, mk(32'h9000_0108), mk(32'h9000_010c));
    chk("full_overflow", LOG_W'(overflow_o), LOG_W'(1'b1));
    chk("full_head", LOG_W'(req_log_o.addr_pc), LOG_W'(32'h9000_0000));
    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, zl, zl);
    chk("ovf_clear", LOG_W'(overflow_o), LOG_W'(1'b0));

    // Drain to three entries, then push one on the pop cycle.
    for (int k = 0; k < 100 && mq.size() > 3; k++) step('0, '0, 1'b1, m_out, 1'b0, 1'b0, zl, zl);
    for (int k = 0; k < 20 && !m_offer; k++) step('0, '0, 1'b0, m_out, 1'b0, 1'b0, zl, zl);
    step(2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, mk(32'h9000_0200), zl);
    drain();

    // Fault on 0x8000_0100; blocks issue until cleared.
    step(2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, mk(32'h8000_0100), mk(32'h8000_0104));
    step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0, zl, zl);
    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, zl, zl);
    step('0, '0, 1'b1, 1'b1, 1'b1, 1'b0, zl, zl);
    chk("flt_fault", LOG_W'(fault_o), LOG_W'(1'b1));
    chk("flt_pc", LOG_W'(fault_log_o.addr_pc), LOG_W'(32'h8000_0100));
    step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0, zl, zl);
    step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0, zl, zl);
    chk("flt_no_req", LOG_W'(req_valid_o), LOG_W'(1'b0));
    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, zl, zl);
    chk("flt_cleared", LOG_W'(fault_o), LOG_W'(1'b0));
    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, zl, zl);
    chk("flt_resume", LOG_W'(req_log_o.addr_pc), LOG_W'(32'h8000_0104));
    chk("flt_resume_v", LOG_W'(req_valid_o), LOG_W'(1'b1));
    drain();

    // Randomized traffic; commit mostly honours stall, occasionally forces a push.
    for (int n = 0; n < 3000; n++) begin
      logic [N-1:0] c, a;
      logic rdy, rv, rf, clr;
      c = N'($urandom);
      a = N'($urandom);
      if (((DEPTH - mq.size()) < N) && ($urandom_range(0, 19) != 0)) a = a & ~c;
      rdy = 1'($urandom_range(0, 1));
      rv  = m_out ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      rf  = rv && ($urandom_range(0, 7) == 0);
      clr = m_flt ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 29) == 0);
      step(c, a, rdy, rv, rf, clr, mk($urandom), mk($urandom));
    end

    // Asynchronous reset while a check is outstanding with four queued.
    if (m_flt) step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, zl, zl);
    drain();
    step(2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, mk(32'hA000_0000), mk(32'hA000_0004));
    step(2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, mk(32'hA000_0008), mk(32'hA000_000c));
    step(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, mk(32'hA000_0010), zl);
    chk("pre_rst_busy", LOG_W'(busy_o), LOG_W'(1'b1));
    #3 rst_i = 1'b1;
    #1;
    chk("arst_busy", LOG_W'(busy_o), LOG_W'(1'b0));
    chk("arst_valid", LOG_W'(req_valid_o), LOG_W'(1'b0));
    chk("arst_stall", LOG_W'(stall_o), LOG_W'(1'b0));
    chk("arst_req_log", req_log_o, '0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    compare_all();
    step('0, '0, 1'b1, 1'b1, 1'b1, 1'b0, zl, zl);
    chk("late_resp_fault", LOG_W'(fault_o), LOG_W'(1'b0));
    step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0, zl, zl);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
